// File: rtl/adaptive_filter_pkg.sv
// Shared configuration, FSM state type and output scaling helper for the serial FIR MAC.
// The fixed-point result is rescaled by 2^-FRAC and clamped to the output sample range.
package adaptive_filter_pkg;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int FRAC  = 15;
  localparam int ACCW  = WIDTH + CW + $clog2(DEPTH);
  localparam int IDXW  = $clog2(DEPTH);

  // Nearest representable value to 1.0 in the coefficient format.
  localparam logic signed [CW-1:0] COEF_IDENT = CW'((1 << FRAC) - 1);

  localparam logic signed [ACCW-1:0] Y_MAX = ACCW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACCW-1:0] Y_MIN = ACCW'(-(64'sd1 <<< (WIDTH - 1)));

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  // Arithmetic shift rounds toward minus infinity before clamping.
  function automatic logic [WIDTH-1:0] sat_shift(input logic signed [ACCW-1:0] acc);
    logic signed [ACCW-1:0] sh;
    sh = acc >>> FRAC;
    if (sh > Y_MAX) begin
      sat_shift = Y_MAX[WIDTH-1:0];
    end else if (sh < Y_MIN) begin
      sat_shift = Y_MIN[WIDTH-1:0];
    end else begin
      sat_shift = sh[WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/serial_fir_mac_mac_acc.sv
// Registered signed multiply-accumulate: one product per enabled cycle, synchronous clear.
// The accumulator is wide enough that DEPTH full-scale products cannot overflow it.
module mac_acc
  import adaptive_filter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [WIDTH-1:0]  a,
  input  logic [CW-1:0]     b,
  output logic [ACCW-1:0]   acc
);

  logic signed [WIDTH+CW-1:0] prod;
  logic signed [ACCW-1:0]     acc_d;
  logic signed [ACCW-1:0]     acc_q;

  always_comb begin
    prod  = $signed(a) * $signed(b);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACCW'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/serial_fir_mac.sv
// Serial FIR dot product: snapshots a tap vector, accumulates DEPTH products through one
// shared multiplier, then holds the scaled/saturated result on a valid/ready port.
module serial_fir_mac
  import adaptive_filter_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DEPTH*WIDTH-1:0]   taps,
  input  logic                     taps_valid,
  output logic                     taps_ready,
  input  logic                     coef_we,
  input  logic [IDXW-1:0]          coef_addr,
  input  logic [CW-1:0]            coef_wdata,
  output logic                     coef_ready,
  output logic [WIDTH-1:0]         y,
  output logic                     y_valid,
  input  logic                     y_ready
);

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            taps_ready_q, taps_ready_d;
  logic            coef_ready_q, coef_ready_d;
  logic            y_valid_q, y_valid_d;
  logic [WIDTH-1:0] tap_q  [DEPTH];
  logic [WIDTH-1:0] tap_d  [DEPTH];
  logic [CW-1:0]    coef_q [DEPTH];
  logic [CW-1:0]    coef_d [DEPTH];

  logic            accept;
  logic            coef_wr;
  logic            mac_clr;
  logic            mac_en;
  logic [ACCW-1:0] acc;

  assign accept  = (state_q == IDLE) && taps_valid && taps_ready_q;
  assign coef_wr = coef_we && coef_ready_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    taps_ready_d = taps_ready_q;
    coef_ready_d = coef_ready_q;
    y_valid_d    = y_valid_q;
    mac_clr      = 1'b0;
    mac_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = MAC;
          idx_d        = '0;
          mac_clr      = 1'b1;
          taps_ready_d = 1'b0;
          coef_ready_d = 1'b0;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        idx_d  = idx_q + IDXW'(1);
        if (idx_q == IDX_LAST) begin
          state_d   = OUT;
          idx_d     = '0;
          y_valid_d = 1'b1;
        end
      end
      OUT: begin
        if (y_ready) begin
          state_d      = IDLE;
          y_valid_d    = 1'b0;
          taps_ready_d = 1'b1;
          coef_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A coefficient written in the same cycle as a tap accept is used by that run.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      tap_d[i]  = accept ? taps[i*WIDTH +: WIDTH] : tap_q[i];
      coef_d[i] = (coef_wr && (coef_addr == IDXW'(i))) ? coef_wdata : coef_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      taps_ready_q <= 1'b1;
      coef_ready_q <= 1'b1;
      y_valid_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tap_q[i]  <= '0;
        coef_q[i] <= (i == 0) ? COEF_IDENT : '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      taps_ready_q <= taps_ready_d;
      coef_ready_q <= coef_ready_d;
      y_valid_q    <= y_valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        tap_q[i]  <= tap_d[i];
        coef_q[i] <= coef_d[i];
      end
    end
  end

  mac_acc u_mac_acc (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (tap_q[idx_q]),
    .b   (coef_q[idx_q]),
    .acc (acc)
  );

  // Accumulator is frozen outside MAC, so y stays stable for the whole OUT phase.
  assign y          = y_valid_q ? sat_shift($signed(acc)) : '0;
  assign y_valid    = y_valid_q;
  assign taps_ready = taps_ready_q;
  assign coef_ready = coef_ready_q;

endmodule

// File: tb/tb_serial_fir_mac.sv
// Directed and randomized checks of serial_fir_mac against a plain-arithmetic dot-product model.
module tb_serial_fir_mac;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int FRAC  = 15;

  logic                   clk;
  logic                   rst;
  logic [DEPTH*WIDTH-1:0] taps;
  logic                   taps_valid;
  logic                   taps_ready;
  logic                   coef_we;
  logic [2:0]             coef_addr;
  logic [CW-1:0]          coef_wdata;
  logic                   coef_ready;
  logic [WIDTH-1:0]       y;
  logic                   y_valid;
  logic                   y_ready;

  int total = 0;
  int bad   = 0;
  int tv [DEPTH];
  int cm [DEPTH];

  serial_fir_mac dut (
    .clk        (clk),
    .rst        (rst),
    .taps       (taps),
    .taps_valid (taps_valid),
    .taps_ready (taps_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_ready (coef_ready),
    .y          (y),
    .y_valid    (y_valid),
    .y_ready    (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // y = clamp(floor(sum(coef*tap) / 2^FRAC))
  function automatic int model_y();
    longint s;
    s = 0;
    for (int i = 0; i < DEPTH; i++) s += longint'(tv[i]) * longint'(cm[i]);
    s = s >>> FRAC;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) cm[i] = 0;
    cm[0] = 32767;
  endtask

  task automatic set_taps();
    for (int i = 0; i < DEPTH; i++) taps[i*WIDTH +: WIDTH] = tv[i][15:0];
  endtask

  task automatic fill_taps(input int v);
    for (int i = 0; i < DEPTH; i++) tv[i] = v;
  endtask

  task automatic write_coef(input int a, input int v);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = 3'(a);
    coef_wdata = v[15:0];
    check($sformatf("coef_ready_w%0d", a), 32'(coef_ready), 1);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    cm[a]   = v;
  endtask

  task automatic run_vector(input string tag, input int exp, input int hold, input bit poke);
    int n;
    @(negedge clk);
    set_taps();
    taps_valid = 1'b1;
    check({tag, ":taps_ready_idle"}, 32'(taps_ready), 1);
    @(posedge clk);
    #1;
    taps       = {$urandom, $urandom, $urandom, $urandom};
    taps_valid = 1'b0;
    n = 0;
    while (y_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        check({tag, ":taps_ready_mac"}, 32'(taps_ready), 0);
        check({tag, ":y_zero_mac"}, $signed(y), 0);
        if (poke) begin
          check({tag, ":coef_ready_mac"}, 32'(coef_ready), 0);
          coef_we    = 1'b1;
          coef_addr  = 3'd0;
          coef_wdata = 16'd0;
        end
      end
      if (n == 3) coef_we = 1'b0;
    end
    coef_we = 1'b0;
    check({tag, ":latency"}, n, DEPTH + 1);
    check({tag, ":y"}, $signed(y), exp);
    taps_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      taps = {$urandom, $urandom, $urandom, $urandom};
      check($sformatf("%s:hold%0d_y", tag, h), $signed(y), exp);
      check($sformatf("%s:hold%0d_valid", tag, h), 32'(y_valid), 1);
      check($sformatf("%s:hold%0d_taps_ready", tag, h), 32'(taps_ready), 0);
    end
    y_ready    = 1'b1;
    taps_valid = 1'b0;
    @(posedge clk);
    #1;
    y_ready = 1'b0;
    @(negedge clk);
    check({tag, ":y_valid_after"}, 32'(y_valid), 0);
    check({tag, ":y_after"}, $signed(y), 0);
    check({tag, ":taps_ready_after"}, 32'(taps_ready), 1);
    $display("txn %s: y=%0d expected=%0d latency=%0d hold=%0d", tag, $signed(y_valid ? y : 16'(exp)), exp, n, hold);
  endtask

  initial begin
    rst        = 1'b1;
    taps       = '0;
    taps_valid = 1'b0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    y_ready    = 1'b0;
    model_reset();
    #1;
    check("reset_y_valid", 32'(y_valid), 0);
    check("reset_y", $signed(y), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_taps_ready", 32'(taps_ready), 1);
    check("reset_coef_ready", 32'(coef_ready), 1);

    // Default coefficients pass tap 0 scaled by 32767/32768.
    fill_taps(0);
    tv[0] = 100;
    run_vector("t1_default", 99, 0, 1'b0);

    // Coefficient write attempted during MAC must be dropped.
    run_vector("t5_drop_write", 99, 0, 1'b1);

    for (int i = 0; i < DEPTH; i++) write_coef(i, 16384);
    fill_taps(1000);
    run_vector("t2_pos", 4000, 0, 1'b0);
    fill_taps(-1000);
    run_vector("t4_hold", -4000, 5, 1'b0);
    fill_taps(1000);
    run_vector("t4_next", 4000, 0, 1'b0);

    for (int i = 0; i < DEPTH; i++) write_coef(i, 32767);
    fill_taps(32767);
    run_vector("t3_sat_pos", 32767, 0, 1'b0);
    fill_taps(-32768);
    run_vector("t3_sat_neg", -32768, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r % 2 == 0) write_coef(i, int'($urandom_range(8192)) - 4096);
        else            write_coef(i, int'($urandom_range(65535)) - 32768);
      end
      for (int i = 0; i < DEPTH; i++) tv[i] = int'($urandom_range(65535)) - 32768;
      run_vector($sformatf("rnd%0d", r), model_y(), int'($urandom_range(2)), 1'b0);
    end

    // Reset in the middle of a MAC run restores the default coefficients.
    fill_taps(0);
    tv[0] = 100;
    @(negedge clk);
    set_taps();
    taps_valid = 1'b1;
    @(posedge clk);
    #1;
    taps_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_y_valid", 32'(y_valid), 0);
    check("t6_rst_y", $signed(y), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_taps_ready", 32'(taps_ready), 1);
    check("t6_coef_ready", 32'(coef_ready), 1);
    run_vector("t6_rerun", 99, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
